instr_encoder: RTL

Instruction encoder and instruction-memory writer for the single-cycle RV32I core. It accepts decoded instruction fields over a valid/ready handshake and assembles each into a 32-bit RV32I word, using the same opcode map the core's main control decoder consumes. Encoded words are buffered in a small FIFO and written sequentially into instruction memory from an auto-incrementing address. Used for self-checking program loading and for driving decoder and datapath tests from field-level stimulus.

---
 rtl/instr_encoder_if.sv | 31 +++
 rtl/instr_encoder.sv | 116 +++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus for instr_encoder.
// The master drives field-level requests and imem_ready; the slave (encoder) drives writes.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [2:0]        in_funct3;
  logic              in_funct7_5;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              imem_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_kind, in_funct3, in_funct7_5, in_rd, in_rs1, in_rs2, in_imm,
           imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_funct3, in_funct7_5, in_rd, in_rs1, in_rs2, in_imm,
           imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: assembles decoded fields into 32-bit words, buffers them
// in a small FIFO and streams them into instruction memory at an auto-incrementing address.
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  instr_encoder_if.slave    bus,
  output logic              err,
  output logic              wrapped
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic [31:0]       enc_word;
  logic              enc_ok;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr_q;
  logic              full;
  logic              empty;
  logic              accept;
  logic              push;
  logic              pop;

  // Field assembly; immediate bits outside each format are simply not selected.
  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b1;
    unique case (bus.in_kind)
      4'd0: enc_word = {1'b0, bus.in_funct7_5, 5'b0, bus.in_rs2, bus.in_rs1,
                        bus.in_funct3, bus.in_rd, OP_R};
      4'd1: begin
        if (bus.in_funct3 == 3'b001 || bus.in_funct3 == 3'b101)
          enc_word = {1'b0, bus.in_funct7_5, 5'b0, bus.in_imm[4:0], bus.in_rs1,
                      bus.in_funct3, bus.in_rd, OP_I_ALU};
        else
          enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_I_ALU};
      end
      4'd2: enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_LOAD};
      4'd3: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        bus.in_imm[4:0], OP_STORE};
      4'd4: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                        bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], OP_BRANCH};
      4'd5: enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                        bus.in_imm[19:12], bus.in_rd, OP_JAL};
      4'd6: enc_word = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, OP_JALR};
      4'd7: enc_word = {bus.in_imm[31:12], bus.in_rd, OP_AUIPC};
      4'd8: enc_word = {bus.in_imm[31:12], bus.in_rd, OP_LUI};
      default: enc_ok = 1'b0;
    endcase
  end

  assign full   = (count == CNT_W'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && enc_ok;
  // No write may leave the block while clr or reset is asserted, even with a word at the head.
  assign pop    = !empty && bus.imem_ready && !clr && !reset;

  assign bus.in_ready   = !full && !clr && !reset;
  assign bus.imem_we    = pop;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      addr_q  <= '0;
      err     <= 1'b0;
      wrapped <= 1'b0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      addr_q  <= '0;
      err     <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        addr_q <= addr_q + ADDR_W'(1);
        if (addr_q == '1) wrapped <= 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (accept && !enc_ok) err <= 1'b1;
    end
  end

endmodule
